// File: rtl/cpa_pipe.sv
// cpa_pipe: segmented, valid-tracked carry-propagate adder that resolves a carry-save pair.
// Defining CPA_MODRED_EN appends one modular-reduction stage (subtract Q once when possible).
module cpa_pipe #(
  parameter int          K   = 33,
  parameter int          SEG = 11,
  parameter logic [K-1:0] Q  = {K{1'b0}}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [K-1:0] c_in,
  input  logic [K-1:0] s_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] sum_out,
  output logic         cout_out
);

  localparam int NSEG = K / SEG;

  logic                     adv_s;
  logic [NSEG-1:0][K-1:0]   c_q_s;
  logic [NSEG-1:0][K-1:0]   s_q_s;
  logic [NSEG-1:0][K-1:0]   res_q_s;
  logic [NSEG-1:0]          cy_q_s;
  logic [NSEG-1:0]          vld_q_s;
  logic                     unused_s;

  // One global enable: the whole pipe moves unless a held result is waiting on the consumer.
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  for (genvar j = 0; j < NSEG; j++) begin : g_stage
    logic [K-1:0] c_prev_s;
    logic [K-1:0] s_prev_s;
    logic [K-1:0] res_prev_s;
    logic [K-1:0] res_next_s;
    logic         cy_prev_s;
    logic         vld_prev_s;
    logic [SEG:0] seg_sum_s;
    logic [K-1:0] c_r;
    logic [K-1:0] s_r;
    logic [K-1:0] res_r;
    logic         cy_r;
    logic         vld_r;

    if (j == 0) begin : g_head
      assign c_prev_s   = c_in;
      assign s_prev_s   = s_in;
      assign res_prev_s = {K{1'b0}};
      assign cy_prev_s  = 1'b0;
      assign vld_prev_s = in_valid;
    end else begin : g_tail
      assign c_prev_s   = c_q_s[j-1];
      assign s_prev_s   = s_q_s[j-1];
      assign res_prev_s = res_q_s[j-1];
      assign cy_prev_s  = cy_q_s[j-1];
      assign vld_prev_s = vld_q_s[j-1];
    end

    assign seg_sum_s = {1'b0, c_prev_s[j*SEG +: SEG]}
                     + {1'b0, s_prev_s[j*SEG +: SEG]}
                     + {{SEG{1'b0}}, cy_prev_s};

    // Splice this stage's segment into the partially resolved sum.
    always_comb begin
      res_next_s                = res_prev_s;
      res_next_s[j*SEG +: SEG]  = seg_sum_s[SEG-1:0];
    end

    // Stage register: operands, partial sum, segment carry and slot valid.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        c_r   <= {K{1'b0}};
        s_r   <= {K{1'b0}};
        res_r <= {K{1'b0}};
        cy_r  <= 1'b0;
        vld_r <= 1'b0;
      end else if (adv_s) begin
        c_r   <= c_prev_s;
        s_r   <= s_prev_s;
        res_r <= res_next_s;
        cy_r  <= seg_sum_s[SEG];
        vld_r <= vld_prev_s;
      end
    end

    assign c_q_s[j]   = c_r;
    assign s_q_s[j]   = s_r;
    assign res_q_s[j] = res_r;
    assign cy_q_s[j]  = cy_r;
    assign vld_q_s[j] = vld_r;
  end

`ifdef CPA_MODRED_EN
  logic [K:0]   red_diff_s;
  logic         red_vld_r;
  logic [K-1:0] red_sum_r;

  // Bit K of the difference is the borrow: set means the sum was already below Q.
  assign red_diff_s = {cy_q_s[NSEG-1], res_q_s[NSEG-1]} - {1'b0, Q};

  // Reduction stage register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_vld_r <= 1'b0;
      red_sum_r <= {K{1'b0}};
    end else if (adv_s) begin
      red_vld_r <= vld_q_s[NSEG-1];
      red_sum_r <= red_diff_s[K] ? res_q_s[NSEG-1] : red_diff_s[K-1:0];
    end
  end

  assign out_valid = red_vld_r;
  assign sum_out   = red_sum_r;
  assign cout_out  = 1'b0;
  assign unused_s  = ^{c_q_s[NSEG-1], s_q_s[NSEG-1]};
`else
  assign out_valid = vld_q_s[NSEG-1];
  assign sum_out   = res_q_s[NSEG-1];
  assign cout_out  = cy_q_s[NSEG-1];
  assign unused_s  = ^{c_q_s[NSEG-1], s_q_s[NSEG-1], Q};
`endif

endmodule

// File: tb/tb_cpa_pipe.sv
// Scoreboard bench for cpa_pipe: accepted beats push c+s (optionally reduced mod Q) into a queue,
// and an output monitor pops and compares every consumed result.
module tb_cpa_pipe;

  localparam int          K    = 33;
  localparam int          SEG  = 11;
  localparam int          NSEG = 3;
  localparam logic [K-1:0] QV  = 33'h0FFFFFFF1;
`ifdef CPA_MODRED_EN
  localparam int L = NSEG + 1;
`else
  localparam int L = NSEG;
`endif

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic [K-1:0] c_in      = {K{1'b0}};
  logic [K-1:0] s_in      = {K{1'b0}};
  logic         in_ready;
  logic         out_valid;
  logic [K-1:0] sum_out;
  logic         cout_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_out  = 0;
  bit lat_chk = 1'b0;
  logic [K:0] exp_q[$];
  int         acc_q[$];

  cpa_pipe #(.K(K), .SEG(SEG), .Q(QV)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .c_in(c_in), .s_in(s_in), .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .cout_out(cout_out)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [K:0] ref_result(input logic [K-1:0] c, input logic [K-1:0] s);
    logic [K+1:0] v;
    v = {2'b00, c} + {2'b00, s};
`ifdef CPA_MODRED_EN
    if (v >= {2'b00, QV}) v = v - {2'b00, QV};
    return {1'b0, v[K-1:0]};
`else
    return v[K:0];
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  task automatic rand_pair(output logic [K-1:0] c, output logic [K-1:0] s);
    logic [63:0] r0, r1;
    r0 = {$urandom, $urandom};
    r1 = {$urandom, $urandom};
`ifdef CPA_MODRED_EN
    s = K'(r0 % 64'(QV));
    c = K'(r1 % 64'(QV));
    c[0] = 1'b0;
`else
    s = {1'b0, r0[K-2:0]};
    c = {r1[K-2:0], 1'b0};
`endif
  endtask

  // Monitor: consumption is decided at the next rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    logic [K:0] e;
    int a;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_output: got %h, expected no result (cycle %0d)", {cout_out, sum_out}, cyc);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        chk("result", 64'({cout_out, sum_out}), 64'(e));
        if (lat_chk) chk("latency", 64'(cyc - a), 64'(L));
        n_out++;
      end
    end
    if (rst_n && in_valid && in_ready) begin
      exp_q.push_back(ref_result(c_in, s_in));
      acc_q.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic one_beat(input logic [K-1:0] c, input logic [K-1:0] s,
                          input logic [K:0] want, input string name);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    c_in      = c;
    s_in      = s;
    tick();
    in_valid  = 1'b0;
    repeat (L - 1) @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk(name, 64'({cout_out, sum_out}), 64'(want));
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [K-1:0] rc, rs;
    int n0;
    bit pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'({cout_out, sum_out}), 64'd0);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    lat_chk = 1'b1;

    // Directed arithmetic; the first beat goes in on the first edge after release
`ifdef CPA_MODRED_EN
    one_beat(33'h000000010, 33'h0FFFFFFF0, 34'h00000000F, "modred_wrap");
    one_beat(33'h000000000, 33'h000000005, 34'h000000005, "modred_small");
`else
    one_beat(33'h000000002, 33'h0FFFFFFFF, 34'h100000001, "carry_ripple");
    one_beat(33'h1FFFFFFFE, 33'h0FFFFFFFF, 34'h2FFFFFFFD, "overflow");
`endif

    // Bubbles: out_valid follows the in_valid pattern L cycles later
    out_ready = 1'b1;
    for (int k = 0; k < 4 + L + 1; k++) begin
      rand_pair(rc, rs);
      c_in     = rc;
      s_in     = rs;
      in_valid = (k < 4) ? pat[k] : 1'b0;
      @(negedge clk);
      chk("bubble_valid", 64'(out_valid), 64'((k >= L && k - L < 4) ? pat[k - L] : 1'b0));
      tick();
    end
    drain("bubble_drain");

    // Back-pressure: beats 1..8, consumer stalls for cycles 4..9
    lat_chk = 1'b0;
    n0 = n_out;
    begin
      int i;
      i = 1;
      for (int t = 0; t < 25; t++) begin
        out_ready = !(t >= 4 && t <= 9);
        in_valid  = (i <= 8);
        c_in      = {K{1'b0}};
        s_in      = K'(i);
        @(negedge clk);
        if (t == 8) begin
          chk("full_in_ready", 64'(in_ready), 64'd0);
          chk("full_out_valid", 64'(out_valid), 64'd1);
        end
        if (in_valid && in_ready) i++;
        tick();
      end
    end
    drain("bp_drain");
    chk("bp_count", 64'(n_out - n0), 64'd8);

    // Reset mid-flight: once with the pipe moving, once stalled with a result held
    for (int ph = 0; ph < 2; ph++) begin
      out_ready = (ph == 0);
      for (int b = 0; b < 2; b++) begin
        rand_pair(rc, rs);
        c_in     = rc;
        s_in     = rs;
        in_valid = 1'b1;
        tick();
      end
      in_valid = 1'b0;
      if (ph == 1) begin
        repeat (3) tick();
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
      end
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_result", 64'({cout_out, sum_out}), 64'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      lat_chk = 1'b1;
      rand_pair(rc, rs);
      one_beat(rc, rs, ref_result(rc, rs), "post_reset");
      repeat (L + 2) tick();
      lat_chk = 1'b0;
    end

    // Randomized traffic with random back-pressure
    n0 = n_out;
    for (int n = 0; n < 300; n++) begin
      rand_pair(rc, rs);
      c_in      = rc;
      s_in      = rs;
      in_valid  = ($urandom_range(9, 0) < 7);
      out_ready = ($urandom_range(9, 0) < 7);
      tick();
    end
    drain("random_drain");
    chk("random_progress", 64'(n_out - n0 > 100), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cpa_pipe.md
CPA_PIPE -- requirements
Module: cpa_pipe

Interface
REQ-001 The module SHALL have parameter K, default 33, giving the operand bit-width of the carry-save pair.
REQ-002 The module SHALL have parameter SEG, default 11, giving the adder segment width; K mod SEG SHALL be 0; NSEG = K/SEG.
REQ-003 The module SHALL have parameter Q, default 0, giving the K-bit modulus used only when CPA_MODRED_EN is defined.
REQ-004 The module SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 The module SHALL have port in_valid  input  1  the carry-save pair on c_in/s_in is valid.
REQ-007 The module SHALL have port in_ready  output  1  the block accepts input this cycle.
REQ-008 The module SHALL have port c_in  input  K  carry vector from the carry-save stage (c_in[0] = 0).
REQ-009 The module SHALL have port s_in  input  K  sum vector from the carry-save stage (s_in[K-1] = 0).
REQ-010 The module SHALL have port out_valid  output  1  sum_out/cout_out hold a result.
REQ-011 The module SHALL have port out_ready  input  1  the downstream consumer accepts the result.
REQ-012 The module SHALL have port sum_out  output  K  the resolved sum, low K bits.
REQ-013 The module SHALL have port cout_out  output  1  bit K of c_in + s_in.

Function
REQ-014 Transfer rules: input is accepted when in_valid && in_ready; output is consumed when out_valid && out_ready.
REQ-015 Pipeline depth L = NSEG stages, plus 1 when CPA_MODRED_EN is defined.
- Each stage has a valid bit.
- Global advance enable: adv = !out_valid || out_ready.
- in_ready = adv, combinational.
REQ-016 Per-stage addition: when adv = 1, stage j (j = 0..NSEG-1) SHALL:
- add segment j of the delayed c/s operands plus the carry registered by stage j-1 (carry 0 for stage 0);
- register the SEG-bit segment result and the carry-out;
- pass upper operand segments and lower result segments forward unchanged.
REQ-017 Latency: an accepted input SHALL appear on out_valid exactly L cycles later when out_ready is held high, with a throughput of one result per cycle.
REQ-018 Stall: when adv = 0 all pipeline registers, valid bits and outputs SHALL hold; no data is lost or duplicated.
REQ-019 Bubbles: stage valid bits SHALL propagate in_valid && adv. Invalid slots advance freely whenever adv = 1.
REQ-020 Simultaneous events: output consumption and input acceptance in the same cycle SHALL both occur.
REQ-021 Result ordering SHALL equal acceptance order.
REQ-022 Arithmetic: {cout_out, sum_out} SHALL equal c_in + s_in computed at K+1 bits, with no truncation.
REQ-023 sum_out and cout_out are don't-care while out_valid = 0, but SHALL be driven from registers.

Reset
REQ-024 Asserting rst_n low SHALL immediately clear all stage valid bits, out_valid, sum_out and cout_out to 0, including mid-operation.
REQ-025 In-flight data SHALL be discarded on reset and no result SHALL be emitted for it.
REQ-026 in_ready SHALL be 1 during and after reset, since adv = 1 when out_valid = 0.
REQ-027 The first input SHALL be accepted in the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro CPA_MODRED_EN, when defined, SHALL add one final stage computing r = {cout, sum} - Q.
- If r >= 0, sum_out = r[K-1:0]; otherwise sum_out = the unreduced sum.
- cout_out SHALL be tied to 0.
- Valid only for inputs with c_in + s_in < 2Q.
REQ-029 When CPA_MODRED_EN is undefined, no reduction logic SHALL exist, L = NSEG, and REQ-022 applies directly.

Verification (K=33, SEG=11, NSEG=3)
REQ-030 Carry ripple: s_in=0x0FFFFFFFF, c_in=0x000000002, one beat, out_ready=1.
- Expect sum_out=0x100000001, cout_out=0 after exactly 3 cycles.
- Carry crosses both segment boundaries.
REQ-031 Overflow: s_in=0x0FFFFFFFF, c_in=0x1FFFFFFFE.
- Expect cout_out=1 and sum_out=0x0FFFFFFFD.
REQ-032 Back-pressure: stream 8 beats with values 1..8 (c_in=0), holding out_ready=0 from cycle 4 to cycle 9.
- Expect in_ready=0 while the pipe is full.
- Expect outputs 1..8 in order with none lost or duplicated.
REQ-033 Reset mid-flight: accept 2 beats, then pull rst_n low for 1 cycle at cycle 2.
- Expect out_valid=0 immediately.
- Expect no stale result after release.
- Expect a new beat to produce its result 3 cycles later.
REQ-034 Throughput with bubbles: in_valid toggling 1,0,1,1 with out_ready=1.
- Expect out_valid pattern 1,0,1,1 shifted by exactly 3 cycles.
REQ-035 With CPA_MODRED_EN, Q=0x0FFFFFFF1 (L=4): s_in=0x0FFFFFFF0, c_in=0x000000010.
- Expect sum_out=0x00000000F, cout_out=0 after 4 cycles.
- s_in=5, c_in=0 SHALL return 5.
